imm_ext_pipe: RTL

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_format.sv | 40 ++++
 rtl/imm_ext_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format codes and helpers for the decode/controller slice.
package imm_pkg;

    typedef enum logic [2:0] {
        I_T   = 3'd0,
        S_T   = 3'd1,
        B_T   = 3'd2,
        J_T   = 3'd3,
        U_T   = 3'd4,
        Z_T   = 3'd5,
        SH_T  = 3'd6,
        RSV_T = 3'd7
    } imm_src_e;

    // Width of the instruction field carried on the request: instr[31:7].
    localparam int unsigned DATA_W = 25;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction and sign/zero extension for RISC-V formats.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        imm_src,
    input  logic [DATA_W-1:0] data,
    output logic [XLEN-1:0]   imm,
    output logic              illegal
);

    // Indexed with true instruction bit numbers so the cases read like the ISA manual.
    logic [31:7] instr;
    logic [5:0]  shamt;

    assign instr = data;

    always_comb begin
        shamt   = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        imm     = '0;
        illegal = 1'b0;
        case (imm_src_e'(imm_src))
            I_T:  imm = XLEN'(sext32({{20{instr[31]}}, instr[31:20]}));
            S_T:  imm = XLEN'(sext32({{20{instr[31]}}, instr[31:25], instr[11:7]}));
            B_T:  imm = XLEN'(sext32({{20{instr[31]}}, instr[7], instr[30:25],
                                      instr[11:8], 1'b0}));
            J_T:  imm = XLEN'(sext32({{12{instr[31]}}, instr[19:12], instr[20],
                                      instr[30:21], 1'b0}));
            U_T:  imm = XLEN'(sext32({instr[31:12], 12'b0}));
            Z_T:  imm = XLEN'(instr[19:15]);
            SH_T: imm = XLEN'(shamt);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a valid/ready pipeline of 1 or 2 register stages.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm_out,
    output logic              illegal
);

    logic [XLEN-1:0]   fmt_imm;
    logic              fmt_ill;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] ill_reg;
    logic [XLEN-1:0]   imm_reg [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_ill;
    logic [XLEN-1:0]   up_imm  [STAGES];

    imm_format #(
        .XLEN(XLEN)
    ) u_format (
        .imm_src (imm_src),
        .data    (data),
        .imm     (fmt_imm),
        .illegal (fmt_ill)
    );

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // A stage can load unless it and every stage after it is full and the sink stalls.
            assign load[gi] = out_ready | ~(&valid_reg[STAGES-1:gi]);

            if (gi == 0) begin : g_head
                assign up_valid[gi] = in_valid;
                assign up_imm[gi]   = fmt_imm;
                assign up_ill[gi]   = fmt_ill;
            end else begin : g_body
                assign up_valid[gi] = valid_reg[gi-1];
                assign up_imm[gi]   = imm_reg[gi-1];
                assign up_ill[gi]   = ill_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            ill_reg   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                imm_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_reg[i] <= up_valid[i];
                    // Payload only moves with a valid upstream, keeping the output quiet when idle.
                    if (up_valid[i]) begin
                        imm_reg[i] <= up_imm[i];
                        ill_reg[i] <= up_ill[i];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_reg[STAGES-1];
    assign imm_out   = imm_reg[STAGES-1];
    assign illegal   = ill_reg[STAGES-1];

endmodule
